// File: rtl/button_repeat.sv
// button_repeat: turns debounced set-hours / set-minutes levels into
// single-cycle increment strobes with hold-to-repeat (slow or fast).
// One shared IDLE -> DELAY -> REPEAT machine serves whichever button
// was pressed first; all timing counts i_tick_stb pulses.
module button_repeat #(
  parameter int CNT_WIDTH   = 12,
  parameter int HOLD_DELAY  = 2048,
  parameter int REPEAT_SLOW = 1024,
  parameter int REPEAT_FAST = 256
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick_stb,
  input  logic i_fast_set_db,
  input  logic i_set_hours_db,
  input  logic i_set_minutes_db,
  output logic o_inc_hours_stb,
  output logic o_inc_minutes_stb,
  output logic o_repeating
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Terminal counter values: a strobe fires on the tick that finds the
  // counter at (period - 1).
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] SLOW_LAST = CNT_WIDTH'(REPEAT_SLOW - 1);
  localparam logic [CNT_WIDTH-1:0] FAST_LAST = CNT_WIDTH'(REPEAT_FAST - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   cnt_s;
  logic                   sel_hours_r;   // 1: hours is the active button
  logic                   sel_hours_s;
  logic                   stb_s;         // increment for the active button
  logic                   active_s;      // level of the active button
  logic [CNT_WIDTH-1:0]   period_last_s;
  logic                   inc_hours_r;
  logic                   inc_minutes_r;
  logic                   repeating_r;

  assign active_s      = sel_hours_r ? i_set_hours_db : i_set_minutes_db;
  // Repeat period is re-evaluated on every tick, so a switch to fast can
  // expire an already-long count immediately (>= compare below).
  assign period_last_s = i_fast_set_db ? FAST_LAST : SLOW_LAST;

  // Next-state, counter and strobe decision for the shared press FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    sel_hours_s = sel_hours_r;
    stb_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (i_set_hours_db) begin
          // Hours wins when both buttons are high.
          sel_hours_s = 1'b1;
          stb_s       = 1'b1;
          state_s     = ST_DELAY;
        end else if (i_set_minutes_db) begin
          sel_hours_s = 1'b0;
          stb_s       = 1'b1;
          state_s     = ST_DELAY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (!active_s) begin
          // Release beats a coincident expiry tick.
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (i_tick_stb) begin
          if (cnt_r == HOLD_LAST) begin
            stb_s   = 1'b1;
            cnt_s   = CNT_ZERO;
            state_s = ST_REPEAT;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_REPEAT: begin
        if (!active_s) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (i_tick_stb) begin
          if (cnt_r >= period_last_s) begin
            stb_s = 1'b1;
            cnt_s = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cnt_s       = CNT_ZERO;
        sel_hours_s = 1'b0;
      end
    endcase
  end

  // FSM state, tick counter and active-button select registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      sel_hours_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      sel_hours_r <= sel_hours_s;
    end
  end

  // Registered outputs: the strobe is routed by the select being loaded,
  // so only one strobe can ever be high.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      inc_hours_r   <= 1'b0;
      inc_minutes_r <= 1'b0;
      repeating_r   <= 1'b0;
    end else begin
      inc_hours_r   <= stb_s & sel_hours_s;
      inc_minutes_r <= stb_s & ~sel_hours_s;
      repeating_r   <= (state_s == ST_REPEAT);
    end
  end

  assign o_inc_hours_stb   = inc_hours_r;
  assign o_inc_minutes_stb = inc_minutes_r;
  assign o_repeating       = repeating_r;

endmodule

// File: tb/tb_button_repeat.sv
// Directed self-checking bench for button_repeat with short timing:
// HOLD_DELAY=8, REPEAT_SLOW=4, REPEAT_FAST=2, one tick every 4 clocks.
module tb_button_repeat;

  logic i_clk;
  logic i_reset_n;
  logic i_tick_stb;
  logic i_fast_set_db;
  logic i_set_hours_db;
  logic i_set_minutes_db;
  logic o_inc_hours_stb;
  logic o_inc_minutes_stb;
  logic o_repeating;

  int errors;
  int checks;
  int hours_cnt;
  int minutes_cnt;
  int both_cnt;
  int rep_any;

  button_repeat #(
    .CNT_WIDTH  (4),
    .HOLD_DELAY (8),
    .REPEAT_SLOW(4),
    .REPEAT_FAST(2)
  ) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_tick_stb       (i_tick_stb),
    .i_fast_set_db    (i_fast_set_db),
    .i_set_hours_db   (i_set_hours_db),
    .i_set_minutes_db (i_set_minutes_db),
    .o_inc_hours_stb  (o_inc_hours_stb),
    .o_inc_minutes_stb(o_inc_minutes_stb),
    .o_repeating      (o_repeating)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: present tick level, take the edge, then observe outputs.
  task automatic step(input logic tk);
    i_tick_stb = tk;
    @(posedge i_clk);
    #1;
    i_tick_stb  = 1'b0;
    hours_cnt   = hours_cnt + int'(o_inc_hours_stb);
    minutes_cnt = minutes_cnt + int'(o_inc_minutes_stb);
    if (o_inc_hours_stb && o_inc_minutes_stb) both_cnt = both_cnt + 1;
    if (o_repeating) rep_any = 1;
  endtask

  // One tick period: three quiet clocks, then the tick clock.
  task automatic tick4();
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
  endtask

  task automatic clear_counts();
    hours_cnt   = 0;
    minutes_cnt = 0;
    rep_any     = 0;
  endtask

  task automatic idle_all();
    i_set_hours_db   = 1'b0;
    i_set_minutes_db = 1'b0;
    i_fast_set_db    = 1'b0;
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    both_cnt = 0;
    clear_counts();
    i_reset_n        = 1'b0;
    i_tick_stb       = 1'b0;
    i_fast_set_db    = 1'b0;
    i_set_hours_db   = 1'b1;
    i_set_minutes_db = 1'b0;

    // Reset state, with a button held and a tick during reset
    step(1'b0);
    step(1'b1);
    check_eq("rst_hours", int'(o_inc_hours_stb), 0);
    check_eq("rst_minutes", int'(o_inc_minutes_stb), 0);
    check_eq("rst_repeating", int'(o_repeating), 0);
    i_set_hours_db = 1'b0;
    i_reset_n = 1'b1;
    step(1'b0);
    step(1'b0);

    // Test 1: short hours press gives a single strobe
    clear_counts();
    i_set_hours_db = 1'b1;
    step(1'b0);
    check_eq("t1_press_stb", int'(o_inc_hours_stb), 1);
    for (int t = 1; t <= 5; t++) tick4();
    i_set_hours_db = 1'b0;
    step(1'b0);
    step(1'b0);
    check_eq("t1_hours_count", hours_cnt, 1);
    check_eq("t1_minutes_count", minutes_cnt, 0);
    check_eq("t1_rep_seen", rep_any, 0);
    idle_all();

    // Test 2: minutes held 21 ticks
    clear_counts();
    i_set_minutes_db = 1'b1;
    step(1'b0);
    check_eq("t2_press_stb", int'(o_inc_minutes_stb), 1);
    check_eq("t2_press_rep", int'(o_repeating), 0);
    minutes_cnt = 0;
    for (int t = 1; t <= 21; t++) begin
      tick4();
      check_eq($sformatf("t2_stb_tick%0d", t), int'(o_inc_minutes_stb),
               (t == 8 || t == 12 || t == 16 || t == 20) ? 1 : 0);
      check_eq($sformatf("t2_rep_tick%0d", t), int'(o_repeating), (t >= 8) ? 1 : 0);
    end
    check_eq("t2_minutes_count", minutes_cnt, 4);
    check_eq("t2_hours_count", hours_cnt, 0);
    i_set_minutes_db = 1'b0;
    step(1'b0);
    check_eq("t2_release_rep", int'(o_repeating), 0);
    check_eq("t2_release_stb", int'(o_inc_minutes_stb), 0);
    idle_all();

    // Test 3: fast-set raised one tick after a repeat strobe
    clear_counts();
    i_set_hours_db = 1'b1;
    step(1'b0);
    for (int t = 1; t <= 8; t++) tick4();
    check_eq("t3_first_repeat", int'(o_inc_hours_stb), 1);
    tick4();
    check_eq("t3_tick9", int'(o_inc_hours_stb), 0);
    i_fast_set_db = 1'b1;
    for (int t = 10; t <= 14; t++) begin
      tick4();
      check_eq($sformatf("t3_fast_tick%0d", t), int'(o_inc_hours_stb),
               (t % 2 == 0) ? 1 : 0);
    end
    // Back to slow lengthens the period; then fast with count already past 1
    i_fast_set_db = 1'b0;
    tick4();
    check_eq("t3_slow_tick15", int'(o_inc_hours_stb), 0);
    tick4();
    check_eq("t3_slow_tick16", int'(o_inc_hours_stb), 0);
    i_fast_set_db = 1'b1;
    tick4();
    check_eq("t3_ge_tick17", int'(o_inc_hours_stb), 1);
    check_eq("t3_hours_count", hours_cnt, 6);
    idle_all();

    // Test 4: both buttons together, then hand over to minutes
    clear_counts();
    i_set_hours_db   = 1'b1;
    i_set_minutes_db = 1'b1;
    step(1'b0);
    check_eq("t4_press_hours", int'(o_inc_hours_stb), 1);
    check_eq("t4_press_minutes", int'(o_inc_minutes_stb), 0);
    for (int t = 1; t <= 9; t++) tick4();
    check_eq("t4_hours_count", hours_cnt, 2);
    check_eq("t4_minutes_count", minutes_cnt, 0);
    i_set_hours_db = 1'b0;
    step(1'b0);
    check_eq("t4_rel_clk1", int'(o_inc_minutes_stb), 0);
    step(1'b0);
    check_eq("t4_rel_clk2", int'(o_inc_minutes_stb), 1);
    idle_all();

    // Test 5: release coincides with the DELAY expiry tick
    clear_counts();
    i_set_minutes_db = 1'b1;
    step(1'b0);
    for (int t = 1; t <= 7; t++) tick4();
    step(1'b0);
    step(1'b0);
    step(1'b0);
    i_set_minutes_db = 1'b0;
    step(1'b1);
    check_eq("t5_no_stb", int'(o_inc_minutes_stb), 0);
    check_eq("t5_not_rep", int'(o_repeating), 0);
    tick4();
    tick4();
    check_eq("t5_minutes_count", minutes_cnt, 1);
    check_eq("t5_rep_seen", rep_any, 0);
    idle_all();

    // Test 6: reset mid-REPEAT with hours held
    clear_counts();
    i_set_hours_db = 1'b1;
    step(1'b0);
    for (int t = 1; t <= 9; t++) tick4();
    check_eq("t6_in_repeat", int'(o_repeating), 1);
    i_reset_n = 1'b0;
    step(1'b0);
    check_eq("t6_rst_hours", int'(o_inc_hours_stb), 0);
    check_eq("t6_rst_rep", int'(o_repeating), 0);
    step(1'b1);
    check_eq("t6_rst_hours2", int'(o_inc_hours_stb), 0);
    check_eq("t6_rst_rep2", int'(o_repeating), 0);
    i_reset_n = 1'b1;
    hours_cnt = 0;
    step(1'b0);
    check_eq("t6_fresh_stb", int'(o_inc_hours_stb), 1);
    for (int t = 1; t <= 7; t++) tick4();
    check_eq("t6_delay_quiet", hours_cnt, 1);
    check_eq("t6_delay_rep", int'(o_repeating), 0);
    tick4();
    check_eq("t6_delay_expiry", int'(o_inc_hours_stb), 1);
    check_eq("t6_repeat_again", int'(o_repeating), 1);
    idle_all();

    check_eq("never_both_strobes", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
